// File: rtl/multiword_add_pkg.sv
// Shared types and sizing helpers for the multi-word add/sub sequencer.
// Imported by the sequencer top and its adder.
package multiword_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int tw_f(input int width, input int words);
    return width * words;
  endfunction

  function automatic int idxw_f(input int words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

endpackage

// File: rtl/lookahead_carry_adder.sv
// WIDTH-bit combinational adder built from generate/propagate terms.
// Carry for bit i+1 is g[i] | p[i] & c[i].
module lookahead_carry_adder #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] p;
  logic [WIDTH:0]   c;

  assign g = a & b;
  assign p = a ^ b;

  always_comb begin
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < WIDTH; i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
    end
  end

  assign sum  = p ^ c[WIDTH-1:0];
  assign cout = c[WIDTH];

endmodule

// File: rtl/multiword_add_sequencer.sv
// Multi-precision add/subtract: one WIDTH-bit adder walked LSW-first
// over WORDS cycles with the carry chained through carry_q.
module multiword_add_sequencer
  import multiword_add_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int WORDS = 4,
  localparam int TW = tw_f(WIDTH, WORDS),
  localparam int IW = idxw_f(WORDS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start_valid,
  output logic          start_ready,
  input  logic          sub,
  input  logic [TW-1:0] op_a,
  input  logic [TW-1:0] op_b,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [TW-1:0] result,
  output logic          cout,
  output logic          ovf,
  output logic          busy
);

  state_t state, state_n;

  logic [TW-1:0]    a_q;
  logic [TW-1:0]    b_q;
  logic             sub_q;
  logic [IW-1:0]    idx_q;
  logic             carry_q;
  logic [TW-1:0]    acc_q;
  logic [TW-1:0]    acc_n;
  logic [TW-1:0]    res_q;
  logic             cout_q;
  logic             ovf_q;

  logic [WIDTH-1:0] a_w;
  logic [WIDTH-1:0] b_w;
  logic [WIDTH-1:0] sum_w;
  logic             co_w;
  logic             cin_msb;
  logic             last;
  logic             accept;

  assign accept  = (state == IDLE) && start_valid;
  assign last    = (idx_q == IW'(WORDS - 1));

  assign a_w     = a_q[int'(idx_q) * WIDTH +: WIDTH];
  assign b_w     = b_q[int'(idx_q) * WIDTH +: WIDTH] ^ {WIDTH{sub_q}};
  assign cin_msb = sum_w[WIDTH-1] ^ a_w[WIDTH-1] ^ b_w[WIDTH-1];

  lookahead_carry_adder #(
    .WIDTH(WIDTH)
  ) u_add (
    .a   (a_w),
    .b   (b_w),
    .cin (carry_q),
    .sum (sum_w),
    .cout(co_w)
  );

  // Words build up in acc_q so the visible result only changes on completion.
  always_comb begin
    acc_n = acc_q;
    acc_n[int'(idx_q) * WIDTH +: WIDTH] = sum_w;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (start_valid) state_n = RUN;
      RUN:     if (last)        state_n = DONE;
      DONE:    if (res_ready)   state_n = IDLE;
      default:                  state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      sub_q   <= 1'b0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      acc_q   <= '0;
      res_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (accept) begin
      a_q     <= op_a;
      b_q     <= op_b;
      sub_q   <= sub;
      carry_q <= sub;
      idx_q   <= '0;
      acc_q   <= '0;
    end else if (state == RUN) begin
      acc_q   <= acc_n;
      carry_q <= co_w;
      if (last) begin
        res_q  <= acc_n;
        cout_q <= co_w;
        ovf_q  <= cin_msb ^ co_w;
      end else begin
        idx_q  <= idx_q + 1'b1;
      end
    end
  end

  assign start_ready = (state == IDLE);
  assign res_valid   = (state == DONE);
  assign busy        = (state != IDLE);
  assign result      = res_q;
  assign cout        = cout_q;
  assign ovf         = ovf_q;

endmodule

// File: doc/multiword_add_sequencer.md
# multiword_add_sequencer

Multi-precision add/subtract engine. Sequences a single WIDTH-bit `lookahead_carry_adder` over WORDS cycles to add or subtract two WIDTH*WORDS-bit operands, with word-to-word carry chaining. It has a valid/ready request port and a valid/ready result port. It sits between the wide-arithmetic command path and the shared adder datapath.

## Interface
- WIDTH, 16, adder word width in bits (≥2)
- WORDS, 4, number of words per operand (≥2); total width TW = WIDTH*WORDS
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous reset, active-low
- start_valid  in  1  request valid
- start_ready  out  1  request accepted when start_valid & start_ready
- sub  in  1  0 = a+b, 1 = a−b; sampled at accept
- op_a  in  TW  operand A; sampled at accept
- op_b  in  TW  operand B; sampled at accept
- res_valid  out  1  result available
- res_ready  in  1  result consumed when res_valid & res_ready
- result  out  TW  sum/difference (mod 2^TW)
- cout  out  1  raw carry out of the top word (for sub: 1 = no borrow)
- ovf  out  1  two's-complement signed overflow
- busy  out  1  high in RUN or DONE

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start_ready=1.
  - On accept: latch op_a, op_b, sub; carry_q←sub; idx←0; go to RUN.
- RUN (start_ready=0):
  - Adder inputs: a = A word[idx], b = B word[idx] ^ {WIDTH{sub}}, cin = carry_q.
  - Each cycle: result word[idx] ← adder sum; carry_q ← adder cout; idx←idx+1.
  - On the cycle idx==WORDS−1, also compute:
    - cout ← adder cout;
    - ovf ← cin_msb ^ adder cout, where cin_msb = sum[W−1] ^ a[W−1] ^ b'[W−1] of the top word.
  - Then go to DONE.
- DONE:
  - res_valid=1. result, cout and ovf are held stable.
  - On res_ready: go to IDLE, res_valid←0. result, cout and ovf keep their values until the next completion.
- A start request is accepted only in IDLE. start_valid in RUN/DONE is ignored and its data is not sampled.
- Words are processed LSW first (word k = bits [k*WIDTH +: WIDTH]).
- Arithmetic is mod 2^TW. No saturation.
- idx is a $clog2(WORDS)-bit counter. It never wraps inside one operation.
- Reset (async, any state, including mid-RUN):
  - state=IDLE, idx=0, carry_q=0.
  - result, cout, ovf = 0; res_valid=0; busy=0; start_ready=1 once rst_n is high.
  - A partially computed result is discarded.

## Timing
- Accept edge = cycle 0. RUN occupies cycles 1..WORDS. res_valid rises WORDS cycles after the accept edge.
- Minimum request-to-request interval: WORDS+2 cycles (accept, WORDS run cycles, 1 DONE cycle with res_ready=1, back in IDLE).
- start_ready and res_valid are registered-state decodes, with no combinational path from start_valid/res_ready.
- Adder path is purely combinational within one cycle. The critical path is a WIDTH-bit carry plus the XOR on b.
- res_valid with res_ready low: remain in DONE indefinitely, all outputs stable.

## Structure
- Package `multiword_add_pkg`:
  - state enum {IDLE, RUN, DONE};
  - localparam helpers for TW and index width.
- One sub-module: a single instance of `lookahead_carry_adder` #(.WIDTH(WIDTH)). No other arithmetic is instantiated.
- Registers: state, idx, carry_q, A/B/sub capture registers, result register, cout/ovf flags.

## Test plan
(WIDTH=16, WORDS=4)
- Carry across one word boundary: add 0x0000_0000_0000_FFFF + 0x1 → result 0x0000_0000_0001_0000, cout=0, ovf=0, res_valid exactly 4 cycles after accept.
- Full carry ripple: add 0xFFFF_FFFF_FFFF_FFFF + 0x1 → result 0x0, cout=1, ovf=0.
- Subtract with borrow: sub=1, 0x0 − 0x1 → result 0xFFFF_FFFF_FFFF_FFFF, cout=0, ovf=0. Then sub=1, 0x5 − 0x3 → 0x2, cout=1.
- Signed overflow: add 0x7FFF_FFFF_FFFF_FFFF + 0x1 → result 0x8000_0000_0000_0000, ovf=1, cout=0. Then sub 0x8000_0000_0000_0000 − 0x1 → 0x7FFF_FFFF_FFFF_FFFF, ovf=1.
- Backpressure: hold res_ready=0 for 3 cycles in DONE while driving start_valid=1 with new operands → result stable, start_ready=0, no capture. After res_ready pulse: IDLE, start_ready=1, and the next accept uses the new operands.
- Reset mid-RUN: assert rst_n=0 at idx=2 → immediately state IDLE, res_valid=0, busy=0, result=0, cout=0, ovf=0. After release, a fresh add of 0x1+0x1 → 0x2.
